// File: rtl/fp_addsub_unit.sv
// fp_addsub_unit: multi-cycle floating-point add/subtract, generic in
// exponent (EXP_W) and stored fraction (MAN_W) width.
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   start         - request, sampled only while idle
//   op            - 00 add (A+B), 01 subtract (A-B), 1x reserved (-> NaN)
//   A, B          - operands, captured when start is accepted
//   R             - registered result, held between done pulses
//   done          - one-cycle pulse, R valid in that cycle
//   busy          - high from ALIGN through DONE
//
// Pipeline: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE, one cycle each.
// Denormal inputs are flushed to zero; tiny results are flushed to zero.
//
// Build option: define FP_ADDSUB_RNE_EN for round-to-nearest-even. Without
// it the unit truncates and overflow saturates to the largest finite value.
module fp_addsub_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  output logic [EXP_W+MAN_W:0] R,
  output logic                 done,
  output logic                 busy
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int FW  = MAN_W + 4;        // hidden, fraction, G, R, S
  localparam int XW  = EXP_W + 2;        // internal exponent, MSB = sign
  localparam int LZW = $clog2(FW + 1);
  localparam int RW  = MAN_W + 2;        // rounding carry, hidden, fraction

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
  state_t state_q, state_d;

  // captured operands (B already sign-flipped for subtract)
  logic [W-1:0]     a_q, b_q;
  logic             bad_op_q;

  // ALIGN
  logic             sa, sb, swap, a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W-1:0] ea, eb, e_big, e_sml, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [W-2:0]     mag_a, mag_b, mag_big, mag_sml;
  logic [FW-1:0]    m_big, m_sml, m_shr, shr_mask, m_aln;
  logic             spec_d;
  logic [W-1:0]     spec_val_d;
  logic             s_q, eff_sub_q, spec_q;
  logic [W-1:0]     spec_val_q;
  logic [XW-1:0]    e_q;
  logic [FW-1:0]    m1_q, m2_q;

  // ADD
  logic [FW:0]      sum_d, sum_q;

  // NORM
  logic [LZW-1:0]   lz;
  logic [FW-1:0]    mn_d, mn_q;
  logic [XW-1:0]    en_d, en_q;
  logic             zero_q;

  // ROUND
  logic             inc;
  logic [RW-1:0]    rm;
  logic [XW-1:0]    er;
  logic [MAN_W-1:0] fr;
  logic [W-1:0]     r_d, r_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign R    = r_q;

  // ---------------- ALIGN ----------------
  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign a_nan = (ea == '1) && (fa != '0);
  assign b_nan = (eb == '1) && (fb != '0);
  assign a_inf = (ea == '1) && (fa == '0);
  assign b_inf = (eb == '1) && (fb == '0);

  // exp==0 means zero (denormals flushed), so the fraction is dropped too
  assign mag_a   = (ea == '0) ? '0 : a_q[W-2:0];
  assign mag_b   = (eb == '0) ? '0 : b_q[W-2:0];
  assign swap    = (mag_b > mag_a);
  assign mag_big = swap ? mag_b : mag_a;
  assign mag_sml = swap ? mag_a : mag_b;
  assign e_big   = mag_big[W-2:MAN_W];
  assign e_sml   = mag_sml[W-2:MAN_W];
  assign diff    = e_big - e_sml;
  assign m_big   = {|e_big, mag_big[MAN_W-1:0], 3'b000};
  assign m_sml   = {|e_sml, mag_sml[MAN_W-1:0], 3'b000};

  // everything shifted past the sticky position is OR-ed into it; huge
  // shifts leave only that sticky bit
  assign shr_mask = ~({FW{1'b1}} << diff);
  assign m_shr    = m_sml >> diff;
  assign m_aln    = {m_shr[FW-1:1], m_shr[0] | (|(m_sml & shr_mask))};

  always_comb begin
    spec_d     = 1'b1;
    spec_val_d = QNAN;
    if (bad_op_q || a_nan || b_nan || (a_inf && b_inf && (sa != sb))) spec_val_d = QNAN;
    else if (a_inf)                                                   spec_val_d = a_q;
    else if (b_inf)                                                   spec_val_d = b_q;
    else                                                              spec_d     = 1'b0;
  end

  // ---------------- ADD ----------------
  assign sum_d = eff_sub_q ? ({1'b0, m1_q} - {1'b0, m2_q})
                           : ({1'b0, m1_q} + {1'b0, m2_q});

  // ---------------- NORM ----------------
  always_comb begin
    lz = '0;
    for (int i = 0; i < FW; i++)
      if (sum_q[i]) lz = LZW'(FW - 1 - i);
    if (sum_q[FW]) begin
      mn_d = {sum_q[FW:2], sum_q[1] | sum_q[0]};
      en_d = e_q + XW'(1);
    end else begin
      mn_d = sum_q[FW-1:0] << lz;
      en_d = e_q - XW'(lz);
    end
  end

  // ---------------- ROUND ----------------
`ifdef FP_ADDSUB_RNE_EN
  assign inc = mn_q[2] & (mn_q[1] | mn_q[0] | mn_q[3]);
`else
  logic grs_unused;
  assign grs_unused = ^mn_q[2:0];  // guard bits only matter when rounding to nearest
  assign inc = 1'b0;
`endif

  assign rm = {1'b0, mn_q[FW-1:3]} + RW'(inc);
  assign er = en_q + XW'(rm[RW-1]);
  assign fr = rm[RW-1] ? rm[MAN_W:1] : rm[MAN_W-1:0];

  always_comb begin
    r_d = {s_q, er[EXP_W-1:0], fr};
    if (spec_q)
      r_d = spec_val_q;
    else if (zero_q)
      r_d = {s_q & ~eff_sub_q, {(W-1){1'b0}}};  // x-x gives +0, -0 + -0 keeps -0
    else if (!er[XW-1] && (er[XW-2:0] >= {1'b0, {EXP_W{1'b1}}}))
`ifdef FP_ADDSUB_RNE_EN
      r_d = {s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
      r_d = {s_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
    else if (er[XW-1] || (er == '0))
      r_d = {s_q, {(W-1){1'b0}}};
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst)                       r_q <= '0;
    else if (state_q == S_ROUND)   r_q <= r_d;
  end

  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: if (start) begin
        a_q      <= A;
        b_q      <= {B[W-1] ^ (op == 2'b01), B[W-2:0]};
        bad_op_q <= op[1];
      end
      S_ALIGN: begin
        s_q        <= swap ? sb : sa;
        eff_sub_q  <= sa ^ sb;
        e_q        <= {2'b00, e_big};
        m1_q       <= m_big;
        m2_q       <= m_aln;
        spec_q     <= spec_d;
        spec_val_q <= spec_val_d;
      end
      S_ADD:  sum_q <= sum_d;
      S_NORM: begin
        mn_q   <= mn_d;
        en_q   <= en_d;
        zero_q <= (sum_q == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fp_addsub_unit.sv
module tb_fp_addsub_unit;
`ifdef FP_ADDSUB_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic        clk, rst;
  logic        start, done, busy;
  logic [1:0]  op;
  logic [31:0] A, B, R;
  logic        start_h, done_h, busy_h;
  logic [1:0]  op_h;
  logic [15:0] A_h, B_h, R_h;

  typedef struct { logic [31:0] a; logic [31:0] b; logic [1:0] op; logic [31:0] r; } vec_t;
  typedef struct { logic [31:0] r; int cyc; int id; } exp_t;

  vec_t tv[20];
  exp_t sbq[$];
  exp_t sbh[$];
  exp_t em, eh;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   k0;

  fp_addsub_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .R(R), .done(done), .busy(busy)
  );

  fp_addsub_unit #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .start(start_h), .op(op_h), .A(A_h), .B(B_h),
    .R(R_h), .done(done_h), .busy(busy_h)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // scoreboards: result and the cycle it must appear in
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done sp: R=%h cyc=%0d", R, cyc);
      end else begin
        em = sbq.pop_front();
        if (R !== em.r || cyc != em.cyc) begin
          n_err++;
          $display("FAIL sp_vec%0d: R=%h at cyc %0d, want R=%h at cyc %0d", em.id, R, cyc, em.r, em.cyc);
        end
      end
    end
    if (done_h === 1'b1) begin
      n_vec++;
      if (sbh.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done hp: R=%h cyc=%0d", R_h, cyc);
      end else begin
        eh = sbh.pop_front();
        if (R_h !== eh.r[15:0] || cyc != eh.cyc) begin
          n_err++;
          $display("FAIL hp_vec%0d: R=%h at cyc %0d, want R=%h at cyc %0d", eh.id, R_h, cyc, eh.r[15:0], eh.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  // called #1 after a rising edge; returns #1 after the edge where the unit is idle again
  task automatic run_op(input vec_t v, input int id);
    exp_t e;
    logic [5:0] bz;
    A = v.a; B = v.b; op = v.op; start = 1'b1;
    e.r = v.r; e.cyc = cyc + 5; e.id = id;
    sbq.push_back(e);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      start = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom);
      bz[k] = busy;
    end
    chk($sformatf("busy_window_vec%0d", id), {26'd0, bz}, 32'h1F);
  endtask

  task automatic run_h(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                       input logic [15:0] r, input int id);
    exp_t e;
    A_h = a; B_h = b; op_h = o; start_h = 1'b1;
    e.r = {16'd0, r}; e.cyc = cyc + 5; e.id = id;
    sbh.push_back(e);
    @(posedge clk); #1;
    start_h = 1'b0; A_h = 16'($urandom); B_h = 16'($urandom);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    start = 1'b0; op = 2'b00; A = '0; B = '0;
    start_h = 1'b0; op_h = 2'b00; A_h = '0; B_h = '0;

    tv[0]  = '{32'h3CA3D70A, 32'h3E99999A, 2'b00, RNE ? 32'h3EA3D70B : 32'h3EA3D70A};
    tv[1]  = '{32'h3FC00000, 32'h40200000, 2'b00, 32'h40800000};
    tv[2]  = '{32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000};
    tv[3]  = '{32'h7F800000, 32'h7F800000, 2'b01, 32'h7FC00000};
    tv[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, RNE ? 32'h7F800000 : 32'h7F7FFFFF};
    tv[5]  = '{32'h3F800000, 32'h3F800000, 2'b10, 32'h7FC00000};
    tv[6]  = '{32'h7FC12345, 32'h3F800000, 2'b00, 32'h7FC00000};
    tv[7]  = '{32'h7F800000, 32'h3F800000, 2'b00, 32'h7F800000};
    tv[8]  = '{32'hFF800000, 32'h7F7FFFFF, 2'b00, 32'hFF800000};
    tv[9]  = '{32'h3F800000, 32'hFF800000, 2'b01, 32'h7F800000};
    tv[10] = '{32'h80000000, 32'h80000000, 2'b00, 32'h80000000};
    tv[11] = '{32'h00000000, 32'h00000000, 2'b01, 32'h00000000};
    tv[12] = '{32'h3F800000, 32'h40400000, 2'b01, 32'hC0000000};
    tv[13] = '{32'h3F800000, 32'h30800000, 2'b00, 32'h3F800000};
    tv[14] = '{32'h3F800000, 32'h33800000, 2'b00, 32'h3F800000};
    tv[15] = '{32'h3F800000, 32'h34400000, 2'b00, RNE ? 32'h3F800002 : 32'h3F800001};
    tv[16] = '{32'h00400000, 32'h00400000, 2'b00, 32'h00000000};
    tv[17] = '{32'h00800000, 32'h00C00000, 2'b01, 32'h80000000};
    tv[18] = '{32'h3F800000, 32'h3F7FFFFF, 2'b01, 32'h33800000};
    tv[19] = '{32'h3F800000, 32'h3F800000, 2'b11, 32'h7FC00000};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_R",    R,                 32'h0);
    chk("reset_done", {31'd0, done},     32'h0);
    chk("reset_busy", {31'd0, busy},     32'h0);
    chk("reset_R_hp", {16'd0, R_h},      32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) run_op(tv[i], i);

    // start held for 12 cycles: two operations, six cycles apart
    k0 = cyc;
    A = 32'h3FC00000; B = 32'h40200000; op = 2'b00; start = 1'b1;
    sbq.push_back('{32'h40800000, k0 + 5,  100});
    sbq.push_back('{32'h40800000, k0 + 11, 101});
    repeat (12) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("R_hold", R, 32'h40800000);

    // reset during NORM aborts the operation with no done
    run_op(tv[12], 200);
    A = 32'h3FC00000; B = 32'h40200000; op = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; B = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_in_norm", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'h0);
    chk("abort_done", {31'd0, done}, 32'h0);
    chk("abort_R",    R,             32'h0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    run_op(tv[0], 201);

    // half precision
    run_h(16'h3C00, 16'h3C00, 2'b00, 16'h4000, 0);
    run_h(16'h7BFF, 16'h0001, 2'b00, 16'h7BFF, 1);
    run_h(16'h3C00, 16'h3C00, 2'b01, 16'h0000, 2);
    run_h(16'h7BFF, 16'h7BFF, 2'b00, RNE ? 16'h7C00 : 16'h7BFF, 3);

    repeat (10) @(posedge clk);
    #1;
    while (sbq.size() != 0) begin
      em = sbq.pop_front();
      n_vec++; n_err++;
      $display("FAIL missing_done sp_vec%0d: got no done, want R=%h at cyc %0d", em.id, em.r, em.cyc);
    end
    while (sbh.size() != 0) begin
      eh = sbh.pop_front();
      n_vec++; n_err++;
      $display("FAIL missing_done hp_vec%0d: got no done, want R=%h at cyc %0d", eh.id, eh.r[15:0], eh.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
